// File: rtl/mlaccel_spi_slave.sv
// -----------------------------------------------------------------------------
// mlaccel_spi_slave
//
// SPI target byte engine for mlaccel_top. Terminates a mode-3 SPI link
// (clock idles high, host drives MOSI on the falling edge and samples MISO on
// the rising edge, MSB first) and turns it into a byte stream for the command
// decoder, while returning response bytes from the core over valid/ready.
//
// The SPI pins are oversampled in the `clock` domain. There is no SPI-clock
// domain: spi_clk is treated as data, synchronized, and edge-detected. The
// SPI half-period must therefore be at least SYNC_STAGES+2 clock cycles.
//
// Ports
//   clock        system clock, every flop in the block
//   resetn       asynchronous active-low reset
//   spi_csb      chip select (active low), asynchronous to clock
//   spi_clk      SPI clock from the host, idles high
//   spi_mosi     host-to-target data
//   spi_miso     target-to-host data (registered)
//   spi_miso_oe  MISO pad enable, high while a transfer is active
//   rx_valid     one-cycle pulse, received byte on rx_data
//   rx_data      received byte, held until the next rx_valid
//   rx_first     qualifies rx_valid: first (command) byte of the transfer
//   tx_valid     core has a response byte on tx_data
//   tx_data      response byte, stable while tx_valid is high
//   tx_ready     one-cycle pulse, byte consumed when tx_valid && tx_ready
//   tx_underrun  one-cycle pulse, IDLE_BYTE loaded because tx_valid was low
//   xfer_active  high while the synchronized chip select is low
//   xfer_end     one-cycle pulse on the synchronized chip-select rising edge
// -----------------------------------------------------------------------------
module mlaccel_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_first,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       xfer_active,
    output logic       xfer_end
);

    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Byte counter only needs to distinguish "first byte" from "later
    // bytes", so it saturates instead of wrapping back to zero.
    function automatic logic [1:0] sat_inc_byte_cnt(input logic [1:0] cnt);
        if (cnt == 2'd2) begin
            return 2'd2;
        end
        return cnt + 2'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Stage p0: pin synchronizers
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] sync_fill;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csb_sync  <= '1;
            clk_sync  <= '1;
            mosi_sync <= '0;
            sync_fill <= '0;
        end else begin
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    logic csb_s;
    logic clk_s;
    logic mosi_s;
    logic sync_full;

    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    // Once every synchronizer stage has been loaded from the pins since
    // reset, the synchronized values reflect the pins rather than reset.
    assign sync_full = sync_fill[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Stage p1: edge detection on the synchronized pins
    // -------------------------------------------------------------------------
    logic csb_prev;
    logic clk_prev;
    logic armed;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csb_prev <= 1'b1;
            clk_prev <= 1'b1;
            armed    <= 1'b0;
        end else begin
            csb_prev <= csb_s;
            clk_prev <= clk_s;
            // A transfer may only start after chip select has been seen
            // high from the pin since reset; a csb-low period that was
            // already in progress when reset released is not a fresh fall.
            if (sync_full && csb_s) begin
                armed <= 1'b1;
            end
        end
    end

    logic csb_fall;
    logic csb_rise;
    logic clk_rise;

    assign csb_fall = armed & csb_prev & ~csb_s;
    assign csb_rise = ~csb_prev & csb_s;
    assign clk_rise = ~clk_prev & clk_s;

    // -------------------------------------------------------------------------
    // Transfer FSM
    // -------------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   start;
    logic   stop;
    logic   shift_en;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chip select has priority over a coincident clock edge in both
    // directions: a clock rise alongside a csb fall is ignored (still IDLE),
    // and a clock rise alongside a csb rise is dropped (stop wins).
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        stop     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (csb_rise) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end else if (clk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage p2: shift registers, byte framing and outputs
    // -------------------------------------------------------------------------
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              byte_done;

    assign byte_done   = shift_en & (bit_cnt == 3'd7);
    // The tx handshake is resolved in the same cycle tx_shift is loaded, so
    // tx_ready marks exactly the cycle the byte is taken.
    assign tx_ready    = byte_done & tx_valid;
    assign tx_underrun = byte_done & ~tx_valid;

    // Receive data path carries no reset; it is fully overwritten by the
    // eight shifts that precede any rx_valid.
    always_ff @(posedge clock) begin
        if (shift_en) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_first    <= 1'b0;
            xfer_active <= 1'b0;
            xfer_end    <= 1'b0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            tx_shift    <= IDLE_BYTE;
        end else begin
            rx_valid <= 1'b0;
            xfer_end <= 1'b0;
            // MISO lags tx_shift by one cycle; the host samples it a full
            // SPI half-period later, so the extra cycle is harmless.
            spi_miso <= tx_shift[DATA_W-1];
            if (start) begin
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                tx_shift    <= IDLE_BYTE;
                spi_miso_oe <= 1'b1;
                xfer_active <= 1'b1;
            end else if (stop) begin
                // Any partial byte is dropped simply by not reporting it;
                // bit_cnt is cleared again on the next start.
                spi_miso_oe <= 1'b0;
                xfer_active <= 1'b0;
                xfer_end    <= 1'b1;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {rx_shift[DATA_W-2:0], mosi_s};
                    rx_first <= (byte_cnt == 2'd0);
                    byte_cnt <= sat_inc_byte_cnt(byte_cnt);
                    tx_shift <= tx_valid ? tx_data : IDLE_BYTE;
                end else begin
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mlaccel_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_mlaccel_spi_slave
//
// Directed bench for mlaccel_spi_slave: a host model drives mode-3 SPI
// transfers with a fixed half-period and a negedge monitor records every
// pulse the block emits. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mlaccel_spi_slave;

    localparam int HALF = 6;

    logic       clock = 1'b0;
    logic       resetn;
    logic       spi_csb;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_underrun;
    logic       xfer_active;
    logic       xfer_end;

    mlaccel_spi_slave #(
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'hFF)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .spi_csb    (spi_csb),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_first   (rx_first),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .xfer_active(xfer_active),
        .xfer_end   (xfer_end)
    );

    always #5 clock = ~clock;

    // Pulse monitor
    int         rx_cnt = 0;
    int         ready_cnt = 0;
    int         under_cnt = 0;
    int         end_cnt = 0;
    logic [7:0] rx_bytes[$];
    logic       rx_firsts[$];

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_cnt = rx_cnt + 1;
            rx_bytes.push_back(rx_data);
            rx_firsts.push_back(rx_first);
        end
        if (tx_ready)    ready_cnt = ready_cnt + 1;
        if (tx_underrun) under_cnt = under_cnt + 1;
        if (xfer_end)    end_cnt = end_cnt + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Host shifts nbits of tx out MSB first; rd collects MISO sampled just
    // before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = tx[7-i];
            wait_cycles(HALF);
            rd = {rd[6:0], spi_miso};
            spi_clk = 1'b1;
            wait_cycles(HALF);
        end
    endtask

    task automatic csb_low();
        spi_csb = 1'b0;
        wait_cycles(2 * HALF);
    endtask

    task automatic csb_high();
        wait_cycles(HALF);
        spi_csb = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    initial begin
        logic [7:0] rd;
        int         rx0;
        int         rdy0;
        int         und0;
        int         end0;

        resetn   = 1'b0;
        spi_csb  = 1'b1;
        spi_clk  = 1'b1;
        spi_mosi = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        wait_cycles(4);

        // Reset state
        check("rst_miso", spi_miso, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_first", rx_first, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        check("rst_xfer_active", xfer_active, 0);
        check("rst_xfer_end", xfer_end, 0);

        resetn = 1'b1;
        wait_cycles(10);

        // SPI clock toggles with csb high are ignored
        rx0 = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b0;
            wait_cycles(HALF);
            spi_clk = 1'b1;
            wait_cycles(HALF);
        end
        check("idle_clk_rx", rx_cnt - rx0, 0);
        check("idle_clk_active", xfer_active, 0);

        // tx byte offered while idle is not consumed
        rdy0     = ready_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        wait_cycles(20);
        check("idle_tx_ready", ready_cnt - rdy0, 0);
        tx_valid = 1'b0;

        // Single-byte write 0x21
        rx0  = rx_cnt;
        end0 = end_cnt;
        und0 = under_cnt;
        csb_low();
        check("single_active", xfer_active, 1);
        check("single_oe", spi_miso_oe, 1);
        spi_bits(8'h21, 8, rd);
        check("single_miso_idle", rd, 8'hFF);
        check("single_underrun", under_cnt - und0, 1);
        csb_high();
        check("single_rx_cnt", rx_cnt - rx0, 1);
        check("single_rx_data", rx_bytes[rx0], 8'h21);
        check("single_rx_first", rx_firsts[rx0], 1);
        check("single_xfer_end", end_cnt - end0, 1);
        check("single_inactive", xfer_active, 0);
        check("single_oe_off", spi_miso_oe, 0);

        // Multi-byte write 0x21, 0xA5, 0x3C
        rx0 = rx_cnt;
        csb_low();
        spi_bits(8'h21, 8, rd);
        spi_bits(8'hA5, 8, rd);
        spi_bits(8'h3C, 8, rd);
        csb_high();
        check("multi_rx_cnt", rx_cnt - rx0, 3);
        check("multi_d0", rx_bytes[rx0], 8'h21);
        check("multi_d1", rx_bytes[rx0+1], 8'hA5);
        check("multi_d2", rx_bytes[rx0+2], 8'h3C);
        check("multi_f0", rx_firsts[rx0], 1);
        check("multi_f1", rx_firsts[rx0+1], 0);
        check("multi_f2", rx_firsts[rx0+2], 0);

        // Response read, then underrun on the following byte
        rdy0     = ready_cnt;
        und0     = under_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        csb_low();
        spi_bits(8'h20, 8, rd);
        check("read_cmd_miso", rd, 8'hFF);
        check("read_ready_once", ready_cnt - rdy0, 1);
        check("read_no_underrun", under_cnt - und0, 0);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        spi_bits(8'h00, 8, rd);
        check("read_miso_5a", rd, 8'h5A);
        check("under_pulse_once", under_cnt - und0, 1);
        spi_bits(8'h00, 8, rd);
        check("under_miso_ff", rd, 8'hFF);
        check("read_ready_total", ready_cnt - rdy0, 1);
        csb_high();

        // Abort after 5 bits, then a clean transfer
        rx0  = rx_cnt;
        end0 = end_cnt;
        csb_low();
        spi_bits(8'hC3, 5, rd);
        csb_high();
        check("abort_rx_cnt", rx_cnt - rx0, 0);
        check("abort_oe", spi_miso_oe, 0);
        check("abort_xfer_end", end_cnt - end0, 1);
        csb_low();
        spi_bits(8'h24, 8, rd);
        csb_high();
        check("abort_next_cnt", rx_cnt - rx0, 1);
        check("abort_next_data", rx_bytes[rx0], 8'h24);
        check("abort_next_first", rx_firsts[rx0], 1);

        // Reset mid-byte after 3 bits
        csb_low();
        spi_bits(8'hE7, 3, rd);
        resetn = 1'b0;
        wait_cycles(2);
        check("mid_rst_oe", spi_miso_oe, 0);
        check("mid_rst_active", xfer_active, 0);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_rx_first", rx_first, 0);
        resetn = 1'b1;
        wait_cycles(20);
        check("post_rst_idle", xfer_active, 0);
        check("post_rst_oe", spi_miso_oe, 0);
        spi_csb = 1'b1;
        wait_cycles(2 * HALF);
        rx0 = rx_cnt;
        csb_low();
        spi_bits(8'h25, 8, rd);
        csb_high();
        check("post_rst_cnt", rx_cnt - rx0, 1);
        check("post_rst_data", rx_bytes[rx0], 8'h25);
        check("post_rst_first", rx_firsts[rx0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
